// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the digital-clock sequencing controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: multi-flop synchronizer followed by a registered rising-edge
// detector. The pulse appears 3 clk after the raw edge; the level output is the synchronized button.
module btn_sync_edge
  import clock_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      level_d <= sync_q[SYNC_STAGES-1];
      pulse   <= sync_q[SYNC_STAGES-1] & ~level_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_set_ctrl.sv
// Digital-clock sequencer: 1 Hz prescaler, RUN carry routing and two-button time-set FSM.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on the increment button.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned REPEAT_DLY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_carry,
  input  logic       min_carry,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       sec_clr,
  output logic       blink_min,
  output logic       blink_hour,
  output logic [1:0] mode
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             phase;
  logic             mode_p, inc_p, inc_go;
  logic             mode_level, inc_level;
  logic             set_exit;

  btn_sync_edge u_mode_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_mode),
    .pulse (mode_p),
    .level (mode_level)
  );

  btn_sync_edge u_inc_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_inc),
    .pulse (inc_p),
    .level (inc_level)
  );

  assign tick     = (cnt == CNT_W'(CLK_DIV - 1));
  assign set_exit = (state == SET_MIN) && mode_p;

  // Leaving SET_MIN restarts the second so the first RUN tick lands a full period later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      phase   <= 1'b0;
      sec_en  <= 1'b0;
      sec_clr <= 1'b0;
      state   <= RUN;
    end else begin
      cnt     <= (tick || set_exit) ? '0 : cnt + 1'b1;
      phase   <= tick ? ~phase : phase;
      sec_en  <= tick && (state == RUN);
      sec_clr <= set_exit;
      state   <= state_nx;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_DLY + 2);

  logic [RPT_W-1:0] rpt_cnt;
  logic             in_set;
  logic             rpt_p;
  logic             unused_sync_level;

  assign in_set = (state == SET_HOUR) || (state == SET_MIN);
  assign rpt_p  = in_set && inc_level && tick && (rpt_cnt == RPT_W'(REPEAT_DLY));
  assign inc_go = inc_p | rpt_p;
  assign unused_sync_level = mode_level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt <= '0;
    end else if (!inc_level || !in_set || (state_nx != state)) begin
      rpt_cnt <= '0;
    end else if (tick && (rpt_cnt != RPT_W'(REPEAT_DLY))) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  logic unused_sync_level;

  assign inc_go = inc_p;
  assign unused_sync_level = &{1'b0, mode_level, inc_level, REPEAT_DLY[0]};
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx   = RUN;
    min_en     = 1'b0;
    hour_en    = 1'b0;
    blink_min  = 1'b0;
    blink_hour = 1'b0;
    case (state)
      RUN: begin
        state_nx = mode_p ? SET_HOUR : RUN;
        min_en   = sec_carry;
        hour_en  = min_carry;
      end
      SET_HOUR: begin
        state_nx   = mode_p ? SET_MIN : SET_HOUR;
        hour_en    = inc_go & ~mode_p;
        blink_hour = phase;
      end
      SET_MIN: begin
        state_nx  = mode_p ? RUN : SET_MIN;
        min_en    = inc_go & ~mode_p;
        blink_min = phase;
      end
      default: state_nx = RUN;
    endcase
  end

  assign mode = state;

endmodule
